// File: rtl/route_demux_pkg.sv
// Shared datapath constants and types for the route demultiplexer.
package route_demux_pkg;

  // Datapath word width.
  localparam int WIDTH = 20;

  // Destination indices carried on in_sel.
  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  // Occupancy of one single-entry holding slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/route_slot.sv
// Single-entry valid/ready holding register with a transfer counter.
// Can drain and reload in the same cycle, so a ready consumer sees no bubbles.
module route_slot #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             slot_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);
  import route_demux_pkg::*;

  slot_state_e state;
  slot_state_e state_nxt;
  logic        drain;

  assign drain      = out_valid & out_ready;
  assign out_valid  = (state == SLOT_FULL);
  // Room for a new word now, or the current word leaves this cycle.
  assign slot_ready = !out_valid | out_ready;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state: fill on load, empty on drain unless refilled in the same cycle.
  // NOTE: state_nxt gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (load)           state_nxt = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
      default:                        state_nxt = SLOT_EMPTY;
    endcase
  end

  // Holding register: changes only when a word is loaded.
  // NOTE: this single word is reset because it must read 0 after reset; bulk storage normally is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_data <= '0;
    else if (load) out_data <= load_data;
  end

  // Completed-transfer counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (drain) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/route_demux.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to port 0
// (memory) or port 1 (I/O). Each port has its own holding slot, so a
// stalled destination never blocks traffic to the other one.
module route_demux #(
  parameter int WIDTH = route_demux_pkg::WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  import route_demux_pkg::*;

  logic slot0_ready;
  logic slot1_ready;
  logic accept;
  logic load0;
  logic load1;

  // Readiness depends only on the selected destination.
  assign in_ready = (in_sel == PORT_MEM) ? slot0_ready : slot1_ready;
  assign accept   = in_valid & in_ready;
  assign load0    = accept & (in_sel == PORT_MEM);
  assign load1    = accept & (in_sel == PORT_IO);

  route_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .slot_ready(slot0_ready),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data),
    .cnt       (cnt0)
  );

  route_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_io (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .slot_ready(slot1_ready),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_route_demux.sv
// Directed bench for route_demux with a per-port scoreboard. Expected words
// are queued when the bench sees an input handshake and checked when the
// matching output handshake occurs; counters and valids follow the model.
module tb_route_demux;
  localparam int W = 20;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sel = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out0_valid;
  logic         out0_ready = 1'b0;
  logic [W-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready = 1'b0;
  logic [W-1:0] out1_data;
  logic [C-1:0] cnt0;
  logic [C-1:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [C-1:0] cnt0_mdl = '0;
  logic [C-1:0] cnt1_mdl = '0;
  logic [C-1:0] base0;
  logic [C-1:0] base1;
  logic [W-1:0] exp_w;

  route_demux #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge (inputs stable), then advance
  // to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("valid0_model", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
      check("valid1_model", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
      check("cnt0_model", {16'd0, cnt0}, {16'd0, cnt0_mdl});
      check("cnt1_model", {16'd0, cnt1}, {16'd0, cnt1_mdl});
      if (out0_valid && out0_ready) begin
        check("sb0_depth", q0.size(), 1);
        if (q0.size() != 0) begin
          exp_w = q0.pop_front();
          check("sb0_data", {12'd0, out0_data}, {12'd0, exp_w});
        end
        cnt0_mdl = cnt0_mdl + 1'b1;
      end
      if (out1_valid && out1_ready) begin
        check("sb1_depth", q1.size(), 1);
        if (q1.size() != 0) begin
          exp_w = q1.pop_front();
          check("sb1_data", {12'd0, out1_data}, {12'd0, exp_w});
        end
        cnt1_mdl = cnt1_mdl + 1'b1;
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    cnt0_mdl = '0;
    cnt1_mdl = '0;
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'($urandom);
      in_sel     = 1'($urandom);
      in_data    = W'($urandom);
      out0_ready = 1'($urandom);
      out1_ready = 1'($urandom);
      tick();
      check("rst_valid0", {31'd0, out0_valid}, 0);
      check("rst_valid1", {31'd0, out1_valid}, 0);
      check("rst_cnt0", {16'd0, cnt0}, 0);
      check("rst_cnt1", {16'd0, cnt1}, 0);
    end
    check("rst_data0", {12'd0, out0_data}, 0);
    check("rst_data1", {12'd0, out1_data}, 0);
    in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    rst_n = 1'b1;
    in_sel = 1'b0; #1;
    check("idle_ready_sel0", {31'd0, in_ready}, 1);
    in_sel = 1'b1; #1;
    check("idle_ready_sel1", {31'd0, in_ready}, 1);
    tick();

    // Single route to port 0.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 20'hABCDE; out0_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid0", {31'd0, out0_valid}, 1);
    check("single_data0", {12'd0, out0_data}, 32'hABCDE);
    check("single_valid1", {31'd0, out1_valid}, 0);
    tick();
    check("single_cnt0", {16'd0, cnt0}, 1);
    check("single_empty0", {31'd0, out0_valid}, 0);

    // Backpressure on port 1.
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 20'h00001;
    tick();
    in_data = 20'h00002; #1;
    check("bp_in_ready", {31'd0, in_ready}, 0);
    tick();
    check("bp_hold_valid", {31'd0, out1_valid}, 1);
    check("bp_hold_data", {12'd0, out1_data}, 32'h00001);
    out1_ready = 1'b1; #1;
    check("bp_release_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    check("bp_reload_valid", {31'd0, out1_valid}, 1);
    check("bp_reload_data", {12'd0, out1_data}, 32'h00002);
    check("bp_cnt1", {16'd0, cnt1}, 1);

    // No head-of-line blocking: port 1 stalled FULL, word goes to port 0.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 20'h12345; out0_ready = 1'b1; #1;
    check("hol_in_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    check("hol_data0", {12'd0, out0_data}, 32'h12345);
    check("hol_valid0", {31'd0, out0_valid}, 1);
    check("hol_valid1", {31'd0, out1_valid}, 1);
    check("hol_data1", {12'd0, out1_data}, 32'h00002);
    // in_ready follows in_sel combinationally while port 1 is stalled.
    in_valid = 1'b1; in_sel = 1'b1; #1;
    check("sel_flip_ready1", {31'd0, in_ready}, 0);
    in_sel = 1'b0; in_valid = 1'b0; #1;
    check("sel_flip_ready0", {31'd0, in_ready}, 1);
    out1_ready = 1'b1;
    tick();
    tick();

    // Streaming: 100 words alternating ports, both consumers ready.
    base0 = cnt0_mdl; base1 = cnt1_mdl;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_sel = 1'(i); in_data = W'(32'h5A000 + i); #1;
      check("stream_in_ready", {31'd0, in_ready}, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_cnt0", {16'd0, cnt0}, {16'd0, base0 + 16'd50});
    check("stream_cnt1", {16'd0, cnt1}, {16'd0, base1 + 16'd50});

    // Counter wrap: clear, then 65536 port-0 transfers.
    #2 rst_n = 1'b0;
    clear_model();
    #1 rst_n = 1'b1;
    tick();
    out0_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_data = W'(i);
      tick();
    end
    in_valid = 1'b0;
    check("wrap_pre_cnt0", {16'd0, cnt0}, 32'hFFFF);
    tick();
    check("wrap_cnt0", {16'd0, cnt0}, 0);
    check("wrap_cnt1", {16'd0, cnt1}, 0);

    // Async reset while both ports are stalled FULL.
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 20'hC0C0C;
    tick();
    in_sel = 1'b1; in_data = 20'hD1D1D;
    tick();
    in_valid = 1'b0;
    check("stall_valid0", {31'd0, out0_valid}, 1);
    check("stall_valid1", {31'd0, out1_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid0", {31'd0, out0_valid}, 0);
    check("async_valid1", {31'd0, out1_valid}, 0);
    check("async_cnt0", {16'd0, cnt0}, 0);
    check("async_data1", {12'd0, out1_data}, 0);
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid0", {31'd0, out0_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
